alu_word_seq: RTL and testbench
===============================

# alu_word_seq

Parallel-word front end for the nibble-serial ALU `tinyqv_alu`. It accepts one 32-bit operation through a valid/ready request port and drives the ALU one nibble per cycle, LSB first, for 8 cycles, chaining carry and compare between nibbles. It then returns the assembled result, carry and compare flag through a valid/ready response port. It lets non-serial blocks (peripherals, debug, coprocessor paths) use the same ALU datapath the core uses.

## Interface
- No parameters; word width fixed at 32, nibble width 4.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_op`  in  4  ALU op: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result this cycle.
- `rsp_d`  out  32  result word.
- `rsp_cy`  out  1  carry out of bit 31 after the final nibble.
- `rsp_cmp`  out  1  final compare chain: SLT/SLTU gives a<b; XOR gives a==b. Other ops leave it unspecified.

## Operation
- States: IDLE, RUN, DONE.
- On reset: state IDLE, nibble counter 0, `rsp_valid`=0, `rsp_d`=0, `rsp_cy`=0, `rsp_cmp`=0.
- IDLE: `req_ready`=1. If `req_valid`, the edge latches op/a/b, clears the counter and enters RUN.
- RUN: the ALU sees `a[4k+:4]`, `b[4k+:4]` with k = counter.
  - At k=0: carry-in = `op[1]|op[3]` and cmp-in = 1.
  - At k>0: carry-in and cmp-in are the previous nibble's registered outputs.
  - Each edge writes `d_out` into `rsp_d[4k+:4]`, registers cy/cmp, and increments the 3-bit counter.
  - On the k=7 edge the counter wraps to 0 and the state enters DONE.
- DONE: `rsp_valid`=1. `rsp_d`, `rsp_cy` and `rsp_cmp` hold stable until `rsp_valid & rsp_ready`. On that edge the state returns to IDLE, or goes to RUN if a skid request is pending (see Configuration).
- Latched operands are immune to later changes of `req_*`.
- Undefined op codes still take 8 cycles; their result is unspecified but the handshake is unchanged.
- `rsp_d` retains the previous result's upper nibbles until they are overwritten. The consumer samples only while `rsp_valid`=1.
- Reset asserted in any state aborts the operation immediately. All outputs return to reset values and no response is produced.

## Timing
- A request accepted on edge E produces `rsp_valid`=1 after edge E+8. Latency is 8 cycles; the handshake adds no extra cycle.
- `req_ready` is combinational from state and skid occupancy only. It never depends on `req_valid`.
- `rsp_valid` is registered.
- With `rsp_ready` held at 1 and without skid: throughput is one operation per 10 cycles (accept, 8 RUN, DONE, then IDLE).
- `rsp_ready` is ignored while `rsp_valid`=0.
- `req_valid` with `req_ready`=0 is not consumed. The requester must hold it.

## Configuration
- `ALU_SEQ_SKID_EN` defined: adds a one-entry request skid register.
  - `req_ready` = skid empty, in every state.
  - Requests accepted in RUN or DONE fill the skid.
  - On the response-handshake edge, a full skid moves into the operand latch, the state goes directly to RUN with counter 0, and the skid empties.
  - A request accepted in IDLE bypasses the skid.
  - Back-to-back throughput with `rsp_ready`=1 is one operation per 9 cycles.
- `ALU_SEQ_SKID_EN` undefined: no skid. `req_ready`=1 only in IDLE.

## Test plan
- ADD a=FFFFFFFF, b=00000001, rsp_ready=1 → rsp_d=00000000, rsp_cy=1; rsp_valid rises exactly 8 cycles after acceptance and is high for one cycle.
- SUB a=5, b=7 → rsp_d=FFFFFFFE. SLT a=FFFFFFFF, b=1 → rsp_cmp=1. SLTU with the same operands → rsp_cmp=0.
- XOR a=b=12345678 → rsp_d=0, rsp_cmp=1. AND/OR with a=F0F0F0F0, b=FF00FF00 → F000F000 / FFF0FFF0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → outputs stable. req_ready=0 without macro. Req_a changed mid-RUN → result unaffected.
- With `ALU_SEQ_SKID_EN`: second request (ADD 1+2) accepted during RUN of the first. Its rsp_valid=1 with rsp_d=3 comes 8 cycles after the first response handshake. A third request is refused while the skid is full.
- rstn pulsed low at counter=3 → rsp_valid stays 0, req_ready=1 after release. A following ADD 2+2 returns 4 with normal latency.

Source files
------------

// File: rtl/alu_word_seq.sv
// alu_word_seq: 32-bit valid/ready front end for a nibble-serial ALU.
// One request is latched, processed LSB nibble first over 8 cycles with carry
// and compare chained between nibbles, and returned on a valid/ready port.
// Optional feature: define ALU_SEQ_SKID_EN for a one-entry request skid register.
module alu_word_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_d,
  output logic        rsp_cy,
  output logic        rsp_cmp
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

`ifdef ALU_SEQ_SKID_EN
  logic        skid_valid_q;
  logic [3:0]  skid_op_q;
  logic [31:0] skid_a_q;
  logic [31:0] skid_b_q;
`endif

  // Nibble datapath signals
  logic [4:0] nib_idx;
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_b_add;
  logic [3:0] nib_d;
  logic [4:0] sum;
  logic       cy_in;
  logic       cmp_in;
  logic       cy_out;
  logic       cmp_out;

  assign nib_idx = {cnt_q, 2'b00};
  assign nib_a   = a_q[nib_idx +: 4];
  assign nib_b   = b_q[nib_idx +: 4];

  // First nibble seeds the chain; later nibbles take the registered outputs,
  // which live directly in rsp_cy / rsp_cmp.
  assign cy_in  = (cnt_q == 3'd0) ? (op_q[1] | op_q[3]) : rsp_cy;
  assign cmp_in = (cnt_q == 3'd0) ? 1'b1 : rsp_cmp;

`ifdef ALU_SEQ_SKID_EN
  assign req_ready = ~skid_valid_q;
`else
  assign req_ready = (state_q == StIdle);
`endif

  // Nibble ALU: add/sub share one adder; compare results are only meaningful on nibble 7.
  always_comb begin
    nib_b_add = (op_q[1] | op_q[3]) ? ~nib_b : nib_b;
    sum       = {1'b0, nib_a} + {1'b0, nib_b_add} + {4'b0000, cy_in};
    cy_out    = sum[4];
    cmp_out   = cmp_in;
    nib_d     = sum[3:0];
    case (op_q[2:0])
      3'b111: nib_d = nib_a & nib_b;
      3'b110: nib_d = nib_a | nib_b;
      3'b100: begin
        nib_d   = nib_a ^ nib_b;
        cmp_out = cmp_in & (nib_a == nib_b);
      end
      // Signed: differing signs decide directly, equal signs fall back to borrow.
      3'b010: cmp_out = (nib_a[3] ^ nib_b[3]) ? nib_a[3] : ~sum[4];
      3'b011: cmp_out = ~sum[4];
      default: begin
      end
    endcase
  end

  // Sequencer FSM with registered response outputs (and optional skid register).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      op_q         <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_d        <= 32'd0;
      rsp_cy       <= 1'b0;
      rsp_cmp      <= 1'b0;
`ifdef ALU_SEQ_SKID_EN
      skid_valid_q <= 1'b0;
      skid_op_q    <= 4'd0;
      skid_a_q     <= 32'd0;
      skid_b_q     <= 32'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            cnt_q   <= 3'd0;
            state_q <= StRun;
          end
        end
        StRun: begin
          rsp_d[nib_idx +: 4] <= nib_d;
          rsp_cy              <= cy_out;
          rsp_cmp             <= cmp_out;
          cnt_q               <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ALU_SEQ_SKID_EN
            if (skid_valid_q) begin
              op_q         <= skid_op_q;
              a_q          <= skid_a_q;
              b_q          <= skid_b_q;
              cnt_q        <= 3'd0;
              skid_valid_q <= 1'b0;
              state_q      <= StRun;
            end else if (req_valid) begin
              // Skid empty on the handshake edge: start the new request
              // directly rather than parking it for a cycle.
              op_q    <= req_op;
              a_q     <= req_a;
              b_q     <= req_b;
              cnt_q   <= 3'd0;
              state_q <= StRun;
            end else begin
              state_q <= StIdle;
            end
`else
            state_q <= StIdle;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef ALU_SEQ_SKID_EN
      // Requests arriving while busy park in the skid (handshake-edge case handled above).
      if ((state_q != StIdle) && req_valid && !skid_valid_q &&
          !((state_q == StDone) && rsp_ready)) begin
        skid_valid_q <= 1'b1;
        skid_op_q    <= req_op;
        skid_a_q     <= req_a;
        skid_b_q     <= req_b;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed self-checking bench for alu_word_seq.
module tb_alu_word_seq;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpXor  = 4'b0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_d;
  logic        rsp_cy;
  logic        rsp_cmp;

  int total = 0;
  int bad   = 0;

  alu_word_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_d     (rsp_d),
    .rsp_cy    (rsp_cy),
    .rsp_cmp   (rsp_cmp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait for the response; lat = cycles from accept edge, -1 on timeout.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int w;
    lat = -1;
    w   = 0;
    while (!req_ready && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!req_ready) return;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_d !== 32'h0) begin bad++; $display("FAIL rst_d got=%h exp=00000000", rsp_d); end
    total++; if (rsp_cy !== 1'b0) begin bad++; $display("FAIL rst_cy got=%b exp=0", rsp_cy); end
    total++; if (rsp_cmp !== 1'b0) begin bad++; $display("FAIL rst_cmp got=%b exp=0", rsp_cmp); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(OpAdd, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL add_latency got=%0d exp=8", lat); end
    total++; if (rsp_d !== 32'h0) begin bad++; $display("FAIL add_d got=%h exp=00000000", rsp_d); end
    total++; if (rsp_cy !== 1'b1) begin bad++; $display("FAIL add_cy got=%b exp=1", rsp_cy); end
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_valid_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_sub();
    int lat;
    issue(OpSub, 32'd5, 32'd7, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL sub_latency got=%0d exp=8", lat); end
    total++; if (rsp_d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_d got=%h exp=fffffffe", rsp_d); end
    total++; if (rsp_cy !== 1'b0) begin bad++; $display("FAIL sub_cy got=%b exp=0", rsp_cy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_compare();
    int lat;
    issue(OpSlt, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL slt_latency got=%0d exp=8", lat); end
    total++; if (rsp_cmp !== 1'b1) begin bad++; $display("FAIL slt_cmp got=%b exp=1", rsp_cmp); end
    @(posedge clk);
    #1;
    issue(OpSltu, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    total++; if (rsp_cmp !== 1'b0) begin bad++; $display("FAIL sltu_cmp got=%b exp=0", rsp_cmp); end
    @(posedge clk);
    #1;
    issue(OpSltu, 32'h0000_0001, 32'hFFFF_FFFF, lat);
    total++; if (rsp_cmp !== 1'b1) begin bad++; $display("FAIL sltu_lt_cmp got=%b exp=1", rsp_cmp); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_xor();
    int lat;
    issue(OpXor, 32'h1234_5678, 32'h1234_5678, lat);
    total++; if (rsp_d !== 32'h0) begin bad++; $display("FAIL xor_eq_d got=%h exp=00000000", rsp_d); end
    total++; if (rsp_cmp !== 1'b1) begin bad++; $display("FAIL xor_eq_cmp got=%b exp=1", rsp_cmp); end
    @(posedge clk);
    #1;
    issue(OpXor, 32'h1234_5678, 32'h1234_5679, lat);
    total++; if (rsp_d !== 32'h1) begin bad++; $display("FAIL xor_ne_d got=%h exp=00000001", rsp_d); end
    total++; if (rsp_cmp !== 1'b0) begin bad++; $display("FAIL xor_ne_cmp got=%b exp=0", rsp_cmp); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_logic();
    int lat;
    issue(OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    total++; if (rsp_d !== 32'hF000_F000) begin bad++; $display("FAIL and_d got=%h exp=f000f000", rsp_d); end
    @(posedge clk);
    #1;
    issue(OpOr, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    total++; if (rsp_d !== 32'hFFF0_FFF0) begin bad++; $display("FAIL or_d got=%h exp=fff0fff0", rsp_d); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic exp_ready_run;
`ifdef ALU_SEQ_SKID_EN
    exp_ready_run = 1'b1;
`else
    exp_ready_run = 1'b0;
`endif
    rsp_ready = 1'b0;
    req_op    = OpAdd;
    req_a     = 32'h1111_1111;
    req_b     = 32'h2222_2222;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++; if (req_ready !== exp_ready_run) begin bad++; $display("FAIL bp_ready_run got=%b exp=%b", req_ready, exp_ready_run); end
    // Operand changes after acceptance must not leak into the result
    req_a = 32'hFFFF_FFFF;
    req_b = 32'hFFFF_FFFF;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", lat); end
    total++; if (rsp_d !== 32'h3333_3333) begin bad++; $display("FAIL bp_d got=%h exp=33333333", rsp_d); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_d !== 32'h3333_3333) begin bad++; $display("FAIL bp_hold_d got=%h exp=33333333", rsp_d); end
      total++; if (rsp_cy !== 1'b0) begin bad++; $display("FAIL bp_hold_cy got=%b exp=0", rsp_cy); end
    end
`ifndef ALU_SEQ_SKID_EN
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_done got=%b exp=0", req_ready); end
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, gap, exp_gap;
    logic prev;
`ifdef ALU_SEQ_SKID_EN
    exp_gap = 9;
`else
    exp_gap = 10;
`endif
    t1 = -1;
    t2 = -1;
    prev = 1'b0;
    rsp_ready = 1'b1;
    req_op    = OpAdd;
    req_a     = 32'd1;
    req_b     = 32'd1;
    req_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid && !prev) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
      prev = rsp_valid;
      if (t2 >= 0) break;
    end
    req_valid = 1'b0;
    gap = (t1 < 0 || t2 < 0) ? -1 : t2 - t1;
    total++; if (gap !== exp_gap) begin bad++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, exp_gap); end
    total++; if (rsp_d !== 32'd2) begin bad++; $display("FAIL b2b_d got=%h exp=00000002", rsp_d); end
    do_reset();
  endtask

`ifdef ALU_SEQ_SKID_EN
  task automatic test_skid();
    int lat;
    logic seen;
    do_reset();
    req_op    = OpAdd;
    req_a     = 32'd10;
    req_b     = 32'd20;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_a = 32'd1;
    req_b = 32'd2;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_empty got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
    req_a = 32'd100;
    req_b = 32'd100;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL skid_ready_full got=%b exp=0", req_ready); end
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL skid_refuse got=%b exp=0", req_ready); end
    req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (rsp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++; if (rsp_d !== 32'd30 || lat < 0) begin bad++; $display("FAIL skid_first_d got=%h exp=0000001e", rsp_d); end
    @(posedge clk);
    #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL skid_second_latency got=%0d exp=8", lat); end
    total++; if (rsp_d !== 32'd3) begin bad++; $display("FAIL skid_second_d got=%h exp=00000003", rsp_d); end
    seen = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL skid_third_dropped got=%b exp=0", seen); end
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    logic seen;
    req_op    = OpAdd;
    req_a     = 32'd5;
    req_b     = 32'd6;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_d !== 32'h0) begin bad++; $display("FAIL rmid_d got=%h exp=00000000", rsp_d); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got=%b exp=0", seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b exp=1", req_ready); end
    issue(OpAdd, 32'd2, 32'd2, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL rmid_add_latency got=%0d exp=8", lat); end
    total++; if (rsp_d !== 32'd4) begin bad++; $display("FAIL rmid_add_d got=%h exp=00000004", rsp_d); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_xor();
    test_logic();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_SEQ_SKID_EN
    test_skid();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
